adc_capture_recorder: RTL and testbench

- Receive-side counterpart to the DAC sample player: takes stereo ADC words from audio_interface, mixes them to mono and decimates them.
- Records the result into a circular on-chip buffer with pre-trigger and post-trigger windows. The trigger is a loudness threshold, which supports voice/clap-triggered game actions.
- Exposes a registered readback port so the game controller or sprite logic can replay or inspect the captured clip.

---
 rtl/adc_capture_pkg.sv | 34 +++
 rtl/adc_capture_recorder_if.sv | 28 ++
 rtl/adc_capture_ram.sv | 30 +++
 rtl/adc_capture_recorder.sv | 153 +++++++++++++++
 tb/tb_adc_capture_recorder.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_capture_pkg.sv
// adc_capture_pkg: shared types and sample arithmetic for the ADC recorder.
// Exports state_t, ADC_W, mono_mix (stereo->mono) and abs_sat (|m|).
package adc_capture_pkg;

  localparam int ADC_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    PRETRIG,
    POSTTRIG,
    DONE
  } state_t;

  // Sum in 17 bits so L+R never overflows.
  // Drop the LSB for an arithmetic halve.
  function automatic logic [ADC_W-1:0] mono_mix(
    input logic [31:0] d
  );
    logic [ADC_W:0] s;
    s = {d[31], d[31:16]} + {d[15], d[15:0]};
    return s[ADC_W:1];
  endfunction

  function automatic logic [ADC_W-1:0] abs_sat(
    input logic [ADC_W-1:0] m
  );
    logic [ADC_W-1:0] r;
    if (m == 16'h8000) r = 16'h7FFF;
    else if (m[ADC_W-1]) r = ~m + 16'd1;
    else r = m;
    return r;
  endfunction

endpackage

// File: rtl/adc_capture_recorder_if.sv
// adc_capture_recorder_if: ADC frame input, capture control and readback.
// master drives adc_full/ADCDATA/arm/abort/rd_addr; slave drives the rest.
interface adc_capture_recorder_if
  import adc_capture_pkg::*;
#(
  parameter int AW = 12
);
  logic             adc_full;
  logic [31:0]      ADCDATA;
  logic             arm;
  logic             abort;
  logic [AW-1:0]    rd_addr;
  logic [ADC_W-1:0] rd_data;
  logic             busy;
  logic             done;
  logic             trig;
  logic [ADC_W-1:0] level;

  modport master (
    output adc_full, ADCDATA, arm, abort, rd_addr,
    input  rd_data, busy, done, trig, level
  );

  modport slave (
    input  adc_full, ADCDATA, arm, abort, rd_addr,
    output rd_data, busy, done, trig, level
  );
endinterface

// File: rtl/adc_capture_ram.sv
// adc_capture_ram: DEPTH x 16 simple dual-port RAM, one write port and a
// registered read port (Clk, Reset, we, waddr, wdata, raddr, rdata).
module adc_capture_ram
  import adc_capture_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [ADC_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [ADC_W-1:0] rdata
);

  logic [ADC_W-1:0] mem [DEPTH];

  always_ff @(posedge Clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the output register is cleared; the array keeps its contents.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) rdata <= '0;
    else rdata <= mem[raddr];
  end

endmodule

// File: rtl/adc_capture_recorder.sv
// adc_capture_recorder: decimated mono ADC capture with pre/post trigger
// windows. Ports: Clk, Reset, bus (slave). Macro ADC_LEVEL_METER_EN.
module adc_capture_recorder
  import adc_capture_pkg::*;
#(
  parameter int          DEPTH  = 4096,
  parameter int          PRE    = 1024,
  parameter int          DECIM  = 6,
  parameter logic [15:0] THRESH = 16'd8000
) (
  input logic                  Clk,
  input logic                  Reset,
  adc_capture_recorder_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;

  state_t           state_q;
  logic             full_q;
  logic [DW-1:0]    dc_q;
  logic [AW-1:0]    wp_q;
  logic [AW-1:0]    sp_q;
  logic [CW-1:0]    fill_q;
  logic [CW-1:0]    post_q;
  logic             trig_q;
  logic             busy_q;
  logic             done_q;

  logic             ev;
  logic             take;
  logic             we;
  logic             hit;
  logic [ADC_W-1:0] m;
  logic [ADC_W-1:0] a;
  logic [AW-1:0]    raddr;

  assign ev    = bus.adc_full & ~full_q;
  assign take  = ev & (dc_q == '0);
  assign m     = mono_mix(bus.ADCDATA);
  assign a     = abs_sat(m);
  assign hit   = (a >= THRESH) & (fill_q == CW'(PRE));
  assign raddr = sp_q + bus.rd_addr;

  // abort and arm both cancel a coincident write.
  assign we = take & ~bus.abort & ~bus.arm
            & ((state_q == PRETRIG) | (state_q == POSTTRIG));

  // Decimation phase runs in every state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      full_q <= 1'b0;
      dc_q   <= '0;
    end else begin
      full_q <= bus.adc_full;
      if (ev) begin
        if (dc_q == DW'(DECIM - 1)) dc_q <= '0;
        else dc_q <= dc_q + DW'(1);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      wp_q    <= '0;
      sp_q    <= '0;
      fill_q  <= '0;
      post_q  <= '0;
      trig_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      trig_q <= 1'b0;
      if (bus.abort) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end else if (bus.arm) begin
        state_q <= PRETRIG;
        wp_q    <= '0;
        fill_q  <= '0;
        post_q  <= '0;
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
      end else if (we) begin
        wp_q <= wp_q + AW'(1);
        unique case (state_q)
          PRETRIG: begin
            if (hit) begin
              // Trigger sample is post sample 0.
              trig_q  <= 1'b1;
              sp_q    <= wp_q - AW'(PRE);
              post_q  <= CW'(1);
              state_q <= POSTTRIG;
            end else if (fill_q != CW'(PRE)) begin
              fill_q <= fill_q + CW'(1);
            end
          end
          POSTTRIG: begin
            post_q <= post_q + CW'(1);
            if (post_q == CW'(DEPTH - PRE - 1)) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  adc_capture_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .Clk   (Clk),
    .Reset (Reset),
    .we    (we),
    .waddr (wp_q),
    .wdata (m),
    .raddr (raddr),
    .rdata (bus.rd_data)
  );

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.trig = trig_q;

`ifdef ADC_LEVEL_METER_EN
  logic [ADC_W-1:0] lvl_q;
  logic [7:0]       lvl_cnt_q;

  // Peak hold; decays by 1/64 once per 256 taken samples.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      lvl_q     <= '0;
      lvl_cnt_q <= '0;
    end else if (take) begin
      lvl_cnt_q <= lvl_cnt_q + 8'd1;
      if (a > lvl_q) lvl_q <= a;
      else if (lvl_cnt_q == 8'hFF) lvl_q <= lvl_q - (lvl_q >> 6);
    end
  end

  assign bus.level = lvl_q;
`else
  assign bus.level = '0;
`endif

endmodule

// File: tb/tb_adc_capture_recorder.sv
// tb_adc_capture_recorder: directed stimulus, a cycle model of the capture
// rules and a per-cycle compare process, plus hand-computed checks.
module tb_adc_capture_recorder;

  localparam int          DEPTH  = 16;
  localparam int          PRE    = 4;
  localparam int          DECIM  = 6;
  localparam int          AW     = 4;
  localparam logic [15:0] THRESH = 16'd1000;

  localparam int S_IDLE = 0;
  localparam int S_PRE  = 1;
  localparam int S_POST = 2;
  localparam int S_DONE = 3;

  logic Clk = 1'b0;
  logic Reset = 1'b1;

  always #5 Clk = ~Clk;

  adc_capture_recorder_if #(.AW(AW)) bus ();

  adc_capture_recorder #(
    .DEPTH  (DEPTH),
    .PRE    (PRE),
    .DECIM  (DECIM),
    .THRESH (THRESH)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int dut_trigs = 0;

  int          m_st = S_IDLE;
  int          m_wp = 0;
  int          m_sp = 0;
  int          m_fill = 0;
  int          m_post = 0;
  int          m_dc = 0;
  bit          m_fq = 1'b0;
  logic [15:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  int          m_writes = 0;
  logic        e_busy = 1'b0;
  logic        e_done = 1'b0;
  logic        e_trig = 1'b0;
  logic [15:0] e_rd = 16'h0;
  bit          rd_ok = 1'b0;

  task automatic chk(input string nm, input logic [15:0] got,
                     input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Floor of (L+R)/2 on plain integers.
  function automatic logic [15:0] fmix(input logic [31:0] d);
    int l, r, s, q;
    l = int'($signed(d[31:16]));
    r = int'($signed(d[15:0]));
    s = l + r;
    if (s >= 0) q = s / 2;
    else q = -((-s + 1) / 2);
    return 16'(q);
  endfunction

  function automatic int fabs(input logic [15:0] v);
    int x;
    x = int'($signed(v));
    if (x < 0) x = -x;
    if (x > 32767) x = 32767;
    return x;
  endfunction

  // Reference model of the capture rules, stepped on each clock.
  initial begin
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
    forever begin
      @(posedge Clk or posedge Reset);
      if (Reset) begin
        m_st = S_IDLE; m_wp = 0; m_sp = 0; m_fill = 0;
        m_post = 0; m_dc = 0; m_fq = 1'b0;
        e_trig = 1'b0; e_rd = 16'h0; rd_ok = 1'b1;
      end else begin
        bit ev, take, wr;
        logic [15:0] mv;
        int av, ra;
        ev = bus.adc_full && !m_fq;
        m_fq = bus.adc_full;
        take = ev && (m_dc == 0);
        if (ev) m_dc = (m_dc + 1) % DECIM;
        mv = fmix(bus.ADCDATA);
        av = fabs(mv);
        wr = take && !bus.abort && !bus.arm
          && (m_st == S_PRE || m_st == S_POST);
        ra = (m_sp + int'(bus.rd_addr)) % DEPTH;
        rd_ok = m_known[ra] && !(wr && m_wp == ra);
        e_rd = m_mem[ra];
        e_trig = 1'b0;
        if (bus.abort) begin
          m_st = S_IDLE;
        end else if (bus.arm) begin
          m_st = S_PRE; m_wp = 0; m_fill = 0; m_post = 0;
        end else if (wr) begin
          m_mem[m_wp] = mv;
          m_known[m_wp] = 1'b1;
          m_writes++;
          if (m_st == S_PRE) begin
            if (av >= int'(THRESH) && m_fill == PRE) begin
              e_trig = 1'b1;
              m_sp = (m_wp - PRE + DEPTH) % DEPTH;
              m_st = S_POST;
              m_post = 1;
            end else if (m_fill < PRE) begin
              m_fill++;
            end
          end else begin
            m_post++;
            if (m_post == DEPTH - PRE) m_st = S_DONE;
          end
          m_wp = (m_wp + 1) % DEPTH;
        end
      end
      e_busy = (m_st == S_PRE || m_st == S_POST);
      e_done = (m_st == S_DONE);
    end
  end

  // Compare process, away from the active edge.
  initial begin
    forever begin
      @(negedge Clk);
      if (bus.trig === 1'b1) dut_trigs++;
      chk("busy", 16'(bus.busy), 16'(e_busy));
      chk("done", 16'(bus.done), 16'(e_done));
      chk("trig", 16'(bus.trig), 16'(e_trig));
      chk("level", bus.level, 16'h0);
      if (rd_ok) chk("rd_data", bus.rd_data, e_rd);
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic frame(input logic [15:0] l, input logic [15:0] r);
    bus.ADCDATA = {l, r};
    bus.adc_full = 1'b1;
    tick(); tick(); tick();
    bus.adc_full = 1'b0;
    tick();
  endtask

  task automatic junk5();
    repeat (5) frame(16'h5555, 16'h5555);
  endtask

  // One taken frame followed by DECIM-1 discarded loud frames.
  task automatic sample(input logic [15:0] l, input logic [15:0] r);
    frame(l, r);
    junk5();
  endtask

  task automatic pulse_arm();
    bus.arm = 1'b1; tick(); bus.arm = 1'b0;
  endtask

  task automatic pulse_abort();
    bus.abort = 1'b1; tick(); bus.abort = 1'b0;
  endtask

  task automatic rb(input string nm, input int a, input logic [15:0] e);
    bus.rd_addr = AW'(a);
    tick();
    chk(nm, bus.rd_data, e);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, w0;
    bus.adc_full = 1'b0;
    bus.ADCDATA = '0;
    bus.arm = 1'b0;
    bus.abort = 1'b0;
    bus.rd_addr = '0;
    tick(); tick();
    chk("rst_busy", 16'(bus.busy), 16'h0);
    chk("rst_done", 16'(bus.done), 16'h0);
    chk("rst_trig", 16'(bus.trig), 16'h0);
    chk("rst_rd", bus.rd_data, 16'h0);
    Reset = 1'b0;
    tick();

    // Pre-fill guard: loud samples before PRE do not trigger.
    pulse_arm();
    t0 = dut_trigs;
    repeat (3) sample(16'd5000, 16'd5000);
    repeat (2) sample(16'd0, 16'd0);
    chk("guard_notrig", 16'(dut_trigs - t0), 16'd0);
    sample(16'd2000, 16'd2000);
    chk("guard_trig", 16'(dut_trigs - t0), 16'd1);
    for (int i = 0; i < 10; i++) sample(16'(10 + i), 16'(10 + i));
    chk("guard_notdone", 16'(bus.done), 16'h0);
    sample(16'd20, 16'd20);
    chk("guard_done", 16'(bus.done), 16'h1);
    rb("guard_rd0", 0, 16'd5000);
    rb("guard_rd1", 1, 16'd5000);
    rb("guard_rd2", 2, 16'd0);
    rb("guard_rd3", 3, 16'd0);
    rb("guard_rd4", 4, 16'd2000);
    rb("guard_rd15", 15, 16'd20);

    // Wrap-around: trigger on sample 29, oldest is sample 25.
    pulse_arm();
    t0 = dut_trigs;
    for (int i = 0; i < 29; i++) sample(16'(i * 7), 16'(i * 7));
    sample(16'hF448, 16'hF448);
    for (int i = 30; i < 41; i++) sample(16'(i * 7), 16'(i * 7));
    chk("wrap_trig", 16'(dut_trigs - t0), 16'd1);
    chk("wrap_done", 16'(bus.done), 16'h1);
    for (int k = 0; k < 16; k++)
      rb("wrap_rd", k, (k == 4) ? 16'hF448 : 16'((25 + k) * 7));

    // Mix and saturation.
    pulse_arm();
    t0 = dut_trigs;
    sample(16'h7FFF, 16'h7FFF);
    sample(16'h7FFF, 16'h8000);
    sample(16'h0064, 16'hFED4);
    sample(16'h0000, 16'h0000);
    chk("mix_notrig", 16'(dut_trigs - t0), 16'd0);
    sample(16'h8000, 16'h8000);
    chk("mix_trig", 16'(dut_trigs - t0), 16'd1);
    repeat (11) sample(16'd1, 16'd1);
    chk("mix_done", 16'(bus.done), 16'h1);
    rb("mix_rd0", 0, 16'h7FFF);
    rb("mix_rd1", 1, 16'hFFFF);
    rb("mix_rd2", 2, 16'hFF9C);
    rb("mix_rd3", 3, 16'h0000);
    rb("mix_rd4", 4, 16'h8000);

    // Decimation: 12 edges, each held 3 cycles, give 2 writes.
    pulse_arm();
    w0 = m_writes;
    repeat (12) frame(16'd100, 16'd100);
    pulse_abort();
    chk("dec_model_writes", 16'(m_writes - w0), 16'd2);
    chk("dec_busy", 16'(bus.busy), 16'h0);
    rb("dec_rd0", 0, 16'd100);
    rb("dec_rd1", 1, 16'd100);
    rb("dec_rd2", 2, 16'hFF9C);
    rb("dec_rd3", 3, 16'h0000);

    // abort on a taken frame: IDLE, word 0 untouched.
    pulse_arm();
    bus.ADCDATA = {16'd777, 16'd777};
    bus.adc_full = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    tick(); tick();
    bus.adc_full = 1'b0;
    tick();
    junk5();
    chk("abort_busy", 16'(bus.busy), 16'h0);
    rb("abort_rd0", 0, 16'd100);

    // arm on a taken frame: restart, frame dropped.
    pulse_arm();
    bus.ADCDATA = {16'd888, 16'd888};
    bus.adc_full = 1'b1;
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    tick(); tick();
    bus.adc_full = 1'b0;
    tick();
    junk5();
    chk("rearm_busy", 16'(bus.busy), 16'h1);
    sample(16'd300, 16'd300);
    pulse_abort();
    rb("rearm_rd0", 0, 16'h012C);
    rb("rearm_rd1", 1, 16'd100);

    // arm in DONE: done drops next cycle and fill restarts at 0.
    pulse_arm();
    sample(16'd2000, 16'd2000);
    repeat (3) sample(16'd1, 16'd1);
    sample(16'd2000, 16'd2000);
    repeat (11) sample(16'd1, 16'd1);
    chk("cap_done", 16'(bus.done), 16'h1);
    pulse_arm();
    chk("rearm_done_lo", 16'(bus.done), 16'h0);
    chk("rearm_busy_hi", 16'(bus.busy), 16'h1);
    t0 = dut_trigs;
    sample(16'd2000, 16'd2000);
    chk("rearm_fill0", 16'(dut_trigs - t0), 16'd0);
    repeat (3) sample(16'd1, 16'd1);
    sample(16'd2000, 16'd2000);
    chk("rearm_trig", 16'(dut_trigs - t0), 16'd1);
    pulse_abort();

    // Reset in POSTTRIG, then a normal capture.
    pulse_arm();
    repeat (4) sample(16'd1, 16'd1);
    sample(16'd2000, 16'd2000);
    repeat (3) sample(16'd2, 16'd2);
    chk("mid_busy", 16'(bus.busy), 16'h1);
    Reset = 1'b1;
    tick();
    chk("mid_rst_busy", 16'(bus.busy), 16'h0);
    chk("mid_rst_done", 16'(bus.done), 16'h0);
    chk("mid_rst_trig", 16'(bus.trig), 16'h0);
    tick();
    Reset = 1'b0;
    tick();
    pulse_arm();
    t0 = dut_trigs;
    for (int i = 0; i < 4; i++) sample(16'(50 + i), 16'(50 + i));
    sample(16'd3000, 16'd3000);
    repeat (11) sample(16'd7, 16'd7);
    chk("post_rst_trig", 16'(dut_trigs - t0), 16'd1);
    chk("post_rst_done", 16'(bus.done), 16'h1);
    rb("post_rst_rd0", 0, 16'd50);
    rb("post_rst_rd3", 3, 16'd53);
    rb("post_rst_rd4", 4, 16'h0BB8);
    rb("post_rst_rd15", 15, 16'd7);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
